// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: CSR addresses, the
// csr_op encoding, mstatus bit positions and interrupt cause codes.
package csr_pkg;

    // Machine-mode CSR addresses
    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MIE       = 12'h304;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MTVAL     = 12'h343;
    localparam logic [11:0] CSR_MIP       = 12'h344;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    // Counter addresses (only implemented when counters are built in)
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

    // CSR instruction operation encoding
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // mstatus bit positions
    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;
    localparam int MSTATUS_MPP_LO   = 11;
    localparam int MSTATUS_MPP_HI   = 12;

    // Interrupt cause codes (also the bit positions in mip/mie)
    localparam int IRQ_MSI_CODE = 3;
    localparam int IRQ_MTI_CODE = 7;
    localparam int IRQ_MEI_CODE = 11;

    // Value a CSR instruction would leave in the register
    function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] cur,
                                                 logic [31:0] operand);
        case (op)
            CSR_OP_RW: return operand;
            CSR_OP_RS: return cur | operand;
            CSR_OP_RC: return cur & ~operand;
            default:   return cur;
        endcase
    endfunction

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit free-running counter with independently writable halves.
// A write to either half takes precedence over the increment for that
// cycle and leaves the other half untouched.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] count
);

    logic [63:0] count_reg;

    // Counter state: half-word writes override the increment, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg <= 64'd0;
        end else if (wr_lo) begin
            count_reg[31:0] <= wdata;
        end else if (wr_hi) begin
            count_reg[63:32] <= wdata;
        end else if (inc) begin
            count_reg <= count_reg + 64'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: CSR read/write, trap entry/return, interrupt
// synchronisation and pending/cause generation.
// Optional feature: define CSR_COUNTERS_EN to add mcycle/minstret and
// their read-only user shadows.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_addr,
    input  logic [1:0]  csr_op,
    input  logic        csr_use_imm,
    input  logic [31:0] rs1_data,
    input  logic [4:0]  csr_imm,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        instr_retire,
    input  logic        irq_ext,
    input  logic        irq_timer,
    input  logic        irq_soft,
    output logic [31:0] trap_vector,
    output logic [31:0] mepc_out,
    output logic        irq_pending,
    output logic [31:0] irq_cause
);

    csr_op_e     op;
    logic [31:0] operand;
    logic        write_req;
    logic        csr_impl;
    logic        csr_we;
    logic [31:0] wdata_next;

    logic        mstatus_mie_reg;
    logic        mstatus_mpie_reg;
    logic [31:0] mie_reg;
    logic [31:0] mtvec_reg;
    logic [31:0] mscratch_reg;
    logic [31:0] mepc_reg;
    logic [31:0] mcause_reg;
    logic [31:0] mtval_reg;
    logic [31:0] mstatus_value;
    logic [31:0] mip_value;

    logic [2:0]  irq_raw;
    logic        irq_meta_reg [3];
    logic        irq_sync_reg [3];

    logic        irq_pending_reg;
    logic [31:0] irq_cause_reg;
    logic        irq_pending_next;
    logic [31:0] irq_cause_next;
    logic [31:0] pend_bits;
    logic [1:0]  hold_cnt_reg;

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_value;
    logic [63:0] minstret_value;
`else
    logic        unused_retire;
    assign unused_retire = instr_retire;
`endif

    assign op        = csr_op_e'(csr_op);
    assign operand   = csr_use_imm ? {27'd0, csr_imm} : rs1_data;
    // RS/RC with a zero operand are pure reads
    assign write_req = (op == CSR_OP_RW) ||
                       (((op == CSR_OP_RS) || (op == CSR_OP_RC)) && (operand != 32'd0));

    always_comb begin
        mstatus_value                                 = 32'd0;
        mstatus_value[MSTATUS_MIE_BIT]                = mstatus_mie_reg;
        mstatus_value[MSTATUS_MPIE_BIT]               = mstatus_mpie_reg;
        mstatus_value[MSTATUS_MPP_HI:MSTATUS_MPP_LO]  = 2'b11;
    end

    always_comb begin
        mip_value               = 32'd0;
        mip_value[IRQ_MEI_CODE] = irq_sync_reg[2];
        mip_value[IRQ_MTI_CODE] = irq_sync_reg[1];
        mip_value[IRQ_MSI_CODE] = irq_sync_reg[0];
    end

    // Read mux and implemented-address decode
    always_comb begin
        csr_rdata = 32'd0;
        csr_impl  = 1'b1;
        case (csr_addr)
            CSR_MSTATUS:   csr_rdata = mstatus_value;
            CSR_MIE:       csr_rdata = mie_reg;
            CSR_MTVEC:     csr_rdata = mtvec_reg;
            CSR_MSCRATCH:  csr_rdata = mscratch_reg;
            CSR_MEPC:      csr_rdata = mepc_reg;
            CSR_MCAUSE:    csr_rdata = mcause_reg;
            CSR_MTVAL:     csr_rdata = mtval_reg;
            CSR_MIP:       csr_rdata = mip_value;
            CSR_MHARTID:   csr_rdata = HART_ID;
`ifdef CSR_COUNTERS_EN
            CSR_MCYCLE,    CSR_CYCLE:    csr_rdata = mcycle_value[31:0];
            CSR_MCYCLEH,   CSR_CYCLEH:   csr_rdata = mcycle_value[63:32];
            CSR_MINSTRET,  CSR_INSTRET:  csr_rdata = minstret_value[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: csr_rdata = minstret_value[63:32];
`endif
            default:       csr_impl  = 1'b0;
        endcase
    end

    // Unimplemented addresses and writes into the read-only space are illegal
    assign csr_illegal = (op != CSR_OP_NONE) &&
                         (!csr_impl || ((csr_addr[11:10] == 2'b11) && write_req));
    // Traps and mret drop any same-cycle CSR write
    assign csr_we      = write_req && !csr_illegal && !trap_valid && !mret_valid;
    assign wdata_next  = csr_apply_op(op, csr_rdata, operand);

    // Architectural state: trap entry beats mret, which beats a CSR write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mstatus_mie_reg  <= 1'b0;
            mstatus_mpie_reg <= 1'b0;
            mie_reg          <= 32'd0;
            mtvec_reg        <= MTVEC_RST;
            mscratch_reg     <= 32'd0;
            mepc_reg         <= 32'd0;
            mcause_reg       <= 32'd0;
            mtval_reg        <= 32'd0;
        end else if (trap_valid) begin
            mepc_reg         <= {trap_pc[31:2], 2'b00};
            mcause_reg       <= trap_cause;
            mtval_reg        <= trap_tval;
            mstatus_mpie_reg <= mstatus_mie_reg;
            mstatus_mie_reg  <= 1'b0;
        end else if (mret_valid) begin
            mstatus_mie_reg  <= mstatus_mpie_reg;
            mstatus_mpie_reg <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: begin
                    mstatus_mie_reg  <= wdata_next[MSTATUS_MIE_BIT];
                    mstatus_mpie_reg <= wdata_next[MSTATUS_MPIE_BIT];
                end
                CSR_MIE:      mie_reg      <= wdata_next;
                CSR_MTVEC:    mtvec_reg    <= {wdata_next[31:2], 1'b0, wdata_next[0]};
                CSR_MSCRATCH: mscratch_reg <= wdata_next;
                CSR_MEPC:     mepc_reg     <= {wdata_next[31:2], 2'b00};
                CSR_MCAUSE:   mcause_reg   <= wdata_next;
                CSR_MTVAL:    mtval_reg    <= wdata_next;
                default:      ;
            endcase
        end
    end

    // Vectored mode only applies to interrupts (cause MSB set)
    always_comb begin
        trap_vector = {mtvec_reg[31:2], 2'b00};
        if (mtvec_reg[0] && trap_cause[31]) begin
            trap_vector = {mtvec_reg[31:2], 2'b00} + {25'd0, trap_cause[4:0], 2'b00};
        end
    end

    assign mepc_out = mepc_reg;

    // Interrupt lines: index 0 soft, 1 timer, 2 external
    assign irq_raw = {irq_ext, irq_timer, irq_soft};

    for (genvar gi = 0; gi < 3; gi++) begin : g_irq_sync
        // Two-flop synchroniser per interrupt line; second flop is the mip bit
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                irq_meta_reg[gi] <= 1'b0;
                irq_sync_reg[gi] <= 1'b0;
            end else begin
                irq_meta_reg[gi] <= irq_raw[gi];
                irq_sync_reg[gi] <= irq_meta_reg[gi];
            end
        end
    end

    // Pending interrupt selection, external > software > timer
    always_comb begin
        pend_bits        = mip_value & mie_reg;
        irq_pending_next = mstatus_mie_reg && (pend_bits != 32'd0);
        irq_cause_next   = 32'd0;
        if (irq_pending_next) begin
            if (pend_bits[IRQ_MEI_CODE]) begin
                irq_cause_next = {1'b1, 31'(IRQ_MEI_CODE)};
            end else if (pend_bits[IRQ_MSI_CODE]) begin
                irq_cause_next = {1'b1, 31'(IRQ_MSI_CODE)};
            end else begin
                irq_cause_next = {1'b1, 31'(IRQ_MTI_CODE)};
            end
        end
    end

    // Registered pending/cause; held off for the first three edges after reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_reg    <= 2'd0;
            irq_pending_reg <= 1'b0;
            irq_cause_reg   <= 32'd0;
        end else begin
            if (hold_cnt_reg != 2'd3) begin
                hold_cnt_reg <= hold_cnt_reg + 2'd1;
            end
            irq_pending_reg <= (hold_cnt_reg == 2'd3) && irq_pending_next;
            irq_cause_reg   <= (hold_cnt_reg == 2'd3) ? irq_cause_next : 32'd0;
        end
    end

    assign irq_pending = irq_pending_reg;
    assign irq_cause   = irq_cause_reg;

`ifdef CSR_COUNTERS_EN
    csr_counter64 u_mcycle (
        .clk   (clk),
        .rst   (rst),
        .inc   (1'b1),
        .wr_lo (csr_we && (csr_addr == CSR_MCYCLE)),
        .wr_hi (csr_we && (csr_addr == CSR_MCYCLEH)),
        .wdata (wdata_next),
        .count (mcycle_value)
    );

    csr_counter64 u_minstret (
        .clk   (clk),
        .rst   (rst),
        .inc   (instr_retire),
        .wr_lo (csr_we && (csr_addr == CSR_MINSTRET)),
        .wr_hi (csr_we && (csr_addr == CSR_MINSTRETH)),
        .wdata (wdata_next),
        .count (minstret_value)
    );
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed testbench for csr_file: CSR access, traps, interrupts, reset.
module tb_csr_file;

    logic        clk;
    logic        rst;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic        csr_use_imm;
    logic [31:0] rs1_data;
    logic [4:0]  csr_imm;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        instr_retire;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    logic [31:0] trap_vector;
    logic [31:0] mepc_out;
    logic        irq_pending;
    logic [31:0] irq_cause;

    int total;
    int bad;

    csr_file #(
        .MTVEC_RST (32'h0000_0040),
        .HART_ID   (32'd5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .csr_addr     (csr_addr),
        .csr_op       (csr_op),
        .csr_use_imm  (csr_use_imm),
        .rs1_data     (rs1_data),
        .csr_imm      (csr_imm),
        .csr_rdata    (csr_rdata),
        .csr_illegal  (csr_illegal),
        .trap_valid   (trap_valid),
        .trap_cause   (trap_cause),
        .trap_pc      (trap_pc),
        .trap_tval    (trap_tval),
        .mret_valid   (mret_valid),
        .instr_retire (instr_retire),
        .irq_ext      (irq_ext),
        .irq_timer    (irq_timer),
        .irq_soft     (irq_soft),
        .trap_vector  (trap_vector),
        .mepc_out     (mepc_out),
        .irq_pending  (irq_pending),
        .irq_cause    (irq_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] data, input logic use_imm, input logic [4:0] imm);
        csr_op      = op;
        csr_addr    = addr;
        rs1_data    = data;
        csr_use_imm = use_imm;
        csr_imm     = imm;
        #1;
    endtask

    task automatic idle();
        csr_op      = 2'b00;
        csr_use_imm = 1'b0;
        rs1_data    = 32'd0;
        csr_imm     = 5'd0;
        trap_valid  = 1'b0;
        mret_valid  = 1'b0;
    endtask

    task automatic check_csr(input string tag, input logic [11:0] addr, input logic [31:0] exp);
        csr_op   = 2'b00;
        csr_addr = addr;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0;
        csr_addr = 12'h000;
        trap_cause = 32'd0;
        trap_pc = 32'd0;
        trap_tval = 32'd0;
        instr_retire = 1'b0;
        irq_ext = 1'b0;
        irq_timer = 1'b0;
        irq_soft = 1'b0;
        idle();

        // Reset state
        tick();
        check_csr("rst_mtvec", 12'h305, 32'h0000_0040);
        check_csr("rst_mstatus", 12'h300, 32'h0000_1800);
        check("rst_pending", {31'd0, irq_pending}, 32'd0);
        check("rst_mepc_out", mepc_out, 32'd0);
        rst = 1'b1;

        // RW mtvec then RC with immediate 1
        drive_op(2'b01, 12'h305, 32'h8000_0003, 1'b0, 5'd0);
        check("rw_mtvec_ill", {31'd0, csr_illegal}, 32'd0);
        tick();
        check_csr("rw_mtvec", 12'h305, 32'h8000_0001);
        drive_op(2'b11, 12'h305, 32'd0, 1'b1, 5'd1);
        tick();
        check_csr("rc_mtvec", 12'h305, 32'h8000_0000);

        // Read-only / unimplemented accesses
        drive_op(2'b01, 12'hF14, 32'hFFFF_FFFF, 1'b0, 5'd0);
        check("rw_hartid_ill", {31'd0, csr_illegal}, 32'd1);
        tick();
        drive_op(2'b10, 12'hF14, 32'd0, 1'b1, 5'd0);
        check("rs0_hartid_ill", {31'd0, csr_illegal}, 32'd0);
        check("rs0_hartid", csr_rdata, 32'd5);
        drive_op(2'b01, 12'h7C0, 32'h1234, 1'b0, 5'd0);
        check("unimpl_ill", {31'd0, csr_illegal}, 32'd1);
        check("unimpl_rdata", csr_rdata, 32'd0);
        check_csr("ill_mtvec_kept", 12'h305, 32'h8000_0000);
        idle();

        // Trap entry and mret
        drive_op(2'b01, 12'h300, 32'h0000_0008, 1'b0, 5'd0);
        tick();
        check_csr("mstatus_mie", 12'h300, 32'h0000_1808);
        trap_valid = 1'b1; trap_cause = 32'd2; trap_pc = 32'h100; trap_tval = 32'hDEAD;
        tick();
        idle();
        check("trap_mepc", mepc_out, 32'h0000_0100);
        check_csr("trap_mcause", 12'h342, 32'd2);
        check_csr("trap_mtval", 12'h343, 32'hDEAD);
        check_csr("trap_mstatus", 12'h300, 32'h0000_1880);
        mret_valid = 1'b1;
        tick();
        idle();
        check_csr("mret_mstatus", 12'h300, 32'h0000_1888);

        // Vectored trap target
        drive_op(2'b01, 12'h305, 32'h0000_1001, 1'b0, 5'd0);
        tick();
        idle();
        check_csr("mtvec_vec", 12'h305, 32'h0000_1001);
        trap_cause = 32'd2;
        #1;
        check("tvec_exc", trap_vector, 32'h0000_1000);
        trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h204; trap_tval = 32'd0;
        #1;
        check("tvec_irq", trap_vector, 32'h0000_101C);
        tick();
        idle();
        mret_valid = 1'b1;
        tick();
        idle();

        // Same-cycle trap + mret + write: only the trap lands
        trap_valid = 1'b1; mret_valid = 1'b1;
        trap_cause = 32'd5; trap_pc = 32'h300;
        drive_op(2'b01, 12'h340, 32'h1234, 1'b0, 5'd0);
        tick();
        idle();
        check_csr("prio_mscratch", 12'h340, 32'd0);
        check("prio_mepc", mepc_out, 32'h300);
        check_csr("prio_mcause", 12'h342, 32'd5);
        check_csr("prio_mstatus", 12'h300, 32'h0000_1880);
        mret_valid = 1'b1;
        drive_op(2'b01, 12'h340, 32'h55, 1'b0, 5'd0);
        tick();
        idle();
        check_csr("mret_wr_scr", 12'h340, 32'd0);
        check_csr("mret_wr_mst", 12'h300, 32'h0000_1888);
        drive_op(2'b01, 12'h340, 32'h55, 1'b0, 5'd0);
        tick();
        drive_op(2'b10, 12'h340, 32'd0, 1'b1, 5'h0A);
        tick();
        check_csr("rs_mscratch", 12'h340, 32'h5F);
        drive_op(2'b01, 12'h341, 32'h123, 1'b0, 5'd0);
        tick();
        idle();
        check("mepc_align", mepc_out, 32'h120);

        // Interrupts: ext+timer rise together
        drive_op(2'b01, 12'h304, 32'h880, 1'b0, 5'd0);
        tick();
        idle();
        irq_ext = 1'b1; irq_timer = 1'b1;
        tick();
        check("irq_e1", {31'd0, irq_pending}, 32'd0);
        tick();
        check("irq_e2", {31'd0, irq_pending}, 32'd0);
        check_csr("mip_read", 12'h344, 32'h880);
        tick();
        check("irq_e3", {31'd0, irq_pending}, 32'd1);
        check("irq_cause_mei", irq_cause, 32'h8000_000B);
        irq_ext = 1'b0;
        tick(); tick(); tick();
        check("irq_cause_mti", irq_cause, 32'h8000_0007);
        drive_op(2'b01, 12'h304, 32'h888, 1'b0, 5'd0);
        irq_soft = 1'b1;
        tick();
        idle();
        tick(); tick();
        check("irq_cause_msi", irq_cause, 32'h8000_0003);
        drive_op(2'b01, 12'h300, 32'd0, 1'b0, 5'd0);
        tick();
        idle();
        tick();
        check("irq_off_pend", {31'd0, irq_pending}, 32'd0);
        check("irq_off_cause", irq_cause, 32'd0);

        // Reset asserted in the middle of a write and a trap
        irq_ext = 1'b1;
        trap_valid = 1'b1; trap_cause = 32'd9; trap_pc = 32'h400;
        drive_op(2'b01, 12'h340, 32'hFFFF, 1'b0, 5'd0);
        #1;
        rst = 1'b0;
        #1;
        check("rstmid_scr", csr_rdata, 32'd0);
        check("rstmid_mepc", mepc_out, 32'd0);
        idle();
        check_csr("rstmid_mtvec", 12'h305, 32'h0000_0040);
        check_csr("rstmid_mcause", 12'h342, 32'd0);
        tick();
        rst = 1'b1;

        // Interrupt pending held off for three edges after reset
        drive_op(2'b01, 12'h304, 32'h880, 1'b0, 5'd0);
        tick();
        check("hold_e1", {31'd0, irq_pending}, 32'd0);
        drive_op(2'b01, 12'h300, 32'h8, 1'b0, 5'd0);
        tick();
        idle();
        check("hold_e2", {31'd0, irq_pending}, 32'd0);
        tick();
        check("hold_e3", {31'd0, irq_pending}, 32'd0);
        tick();
        check("hold_e4", {31'd0, irq_pending}, 32'd1);
        check("hold_cause", irq_cause, 32'h8000_000B);

`ifdef CSR_COUNTERS_EN
        // mcycle wrap after writing both halves to all-ones
        drive_op(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 5'd0);
        tick();
        drive_op(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0, 5'd0);
        tick();
        idle();
        check_csr("mcycle_lo_max", 12'hB00, 32'hFFFF_FFFF);
        check_csr("mcycle_hi_max", 12'hB80, 32'hFFFF_FFFF);
        tick();
        check_csr("mcycle_lo_wrap", 12'hB00, 32'd0);
        check_csr("mcycle_hi_wrap", 12'hB80, 32'd0);
        tick();
        check_csr("cycle_shadow", 12'hC00, 32'd1);
        drive_op(2'b01, 12'hC00, 32'd1, 1'b0, 5'd0);
        check("cycle_wr_ill", {31'd0, csr_illegal}, 32'd1);
        idle();
`else
        // Counter addresses are unimplemented in the default build
        drive_op(2'b10, 12'hB00, 32'd0, 1'b1, 5'd0);
        check("mcycle_ill", {31'd0, csr_illegal}, 32'd1);
        check("mcycle_rdata", csr_rdata, 32'd0);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
